// File: rtl/sar_pkg.sv
// Shared definitions for the SAR averaging buffer: default code width,
// accumulator width helper, FSM state encoding and the result record.
package sar_pkg;

  localparam int unsigned DATA_W = 6;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } sarState_t;

  // One finished block as it travels through the result FIFO.
  typedef struct packed {
    logic [DATA_W-1:0] avg;
    logic [DATA_W-1:0] minCode;
    logic [DATA_W-1:0] maxCode;
  } sarResult_t;

  // Block sum plus one guard bit so the rounding term can never wrap.
  function automatic int unsigned accW(input int unsigned dataW,
                                       input int unsigned log2Avg);
    return dataW + log2Avg + 1;
  endfunction

endpackage

// File: rtl/sar_result_fifo.sv
// First-word-fall-through result FIFO with registered head and status.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous empty (wins over push/pop)
//   push, pushData  write request and payload (ignored when full without pop)
//   pop             consumer ready; a pop happens only when popValid=1
//   popValid        head entry valid
//   popData         head entry (0 when empty)
//   full, empty     registered status
//   level           registered occupancy 0..DEPTH
module sar_result_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic             popValid,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtrNext;
  logic [PTR_W-1:0] rdPtrNext;
  logic [LVL_W-1:0] levelNext;
  logic [WIDTH-1:0] headNext;
  logic             wrEn;
  logic             rdEn;

  // A write into a full FIFO is allowed only when the head leaves the same cycle.
  assign rdEn = pop & popValid & ~flush;
  assign wrEn = push & ~flush & (~full | rdEn);

  // Next pointers/occupancy and the value the head register must show next.
  always_comb begin
    wrPtrNext = wrPtr + PTR_W'(wrEn);
    rdPtrNext = rdPtr + PTR_W'(rdEn);
    levelNext = level + LVL_W'(wrEn) - LVL_W'(rdEn);
    headNext  = '0;
    if (flush) begin
      wrPtrNext = '0;
      rdPtrNext = '0;
      levelNext = '0;
    end else if (levelNext != '0) begin
      // Bypass the array when the new head is being written this cycle.
      if (wrEn && (wrPtr == rdPtrNext)) begin
        headNext = pushData;
      end else begin
        headNext = mem[rdPtrNext];
      end
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Pointers, head register and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      popValid <= 1'b0;
      popData  <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      wrPtr    <= wrPtrNext;
      rdPtr    <= rdPtrNext;
      level    <= levelNext;
      popValid <= (levelNext != '0);
      popData  <= headNext;
      full     <= (levelNext == LVL_W'(DEPTH));
      empty    <= (levelNext == '0);
    end
  end

endmodule

// File: rtl/sar_avg_buffer.sv
// Block averager behind the SAR converter: accumulates 2^LOG2_AVG codes,
// produces the rounded average with block min/max and queues it in a FWFT
// FIFO so the reader can stall without back-pressuring the converter.
// Ports:
//   clk_in, rst_in          clock, asynchronous active-low reset
//   conv_done_in/code_in    one-cycle conversion strobe and code
//   avg_en_in               1 = accumulate, 0 = idle (partial block dropped)
//   clear_in                synchronous flush of FIFO, accumulator, overrun
//   avg_ready_in            consumer ready
//   avg_valid_out, avg_data_out, avg_min_out, avg_max_out   FIFO head
//   overrun_out             sticky: a finished block was dropped
//   level_out               FIFO occupancy
module sar_avg_buffer
  import sar_pkg::*;
#(
  parameter int unsigned DATA_W     = sar_pkg::DATA_W,
  parameter int unsigned LOG2_AVG   = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              conv_done_in,
  input  logic [DATA_W-1:0] conv_code_in,
  input  logic              avg_en_in,
  input  logic              clear_in,
  input  logic              avg_ready_in,
  output logic              avg_valid_out,
  output logic [DATA_W-1:0] avg_data_out,
  output logic [DATA_W-1:0] avg_min_out,
  output logic [DATA_W-1:0] avg_max_out,
  output logic              overrun_out,
  output logic [LVL_W-1:0]  level_out
);

  localparam int unsigned ACC_W = accW(DATA_W, LOG2_AVG);
  localparam int unsigned CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int unsigned RES_W = 3 * DATA_W;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'((1 << LOG2_AVG) - 1);
  localparam logic [ACC_W-1:0] ROUND_TERM = ACC_W'((1 << LOG2_AVG) >> 1);
  localparam logic [ACC_W-1:0] CODE_MAX   = ACC_W'((1 << DATA_W) - 1);

  // The result record is sized by the package width.
  if (DATA_W != sar_pkg::DATA_W) begin : gDataWCheck
    $error("sar_avg_buffer: DATA_W must match sar_pkg::DATA_W");
  end

  sarState_t         state;
  sarState_t         stateNext;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  accNext;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cntNext;
  logic [DATA_W-1:0] blkMin;
  logic [DATA_W-1:0] blkMinNext;
  logic [DATA_W-1:0] blkMax;
  logic [DATA_W-1:0] blkMaxNext;
  logic              pushValid;
  logic              pushValidNext;
  sarResult_t        pushData;
  sarResult_t        pushDataNext;
  logic              overrunNext;

  logic [ACC_W-1:0]  sumFull;
  logic [ACC_W-1:0]  rounded;
  logic [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0] avgSat;
  logic [DATA_W-1:0] sampleMin;
  logic [DATA_W-1:0] sampleMax;
  logic              firstSample;
  logic              sampleEn;
  logic              blockEnd;
  logic              fifoDrop;

  logic              fifoFull;
  logic              fifoEmpty;
  sarResult_t        headData;

  // Sample-path arithmetic: running sum, rounded/saturated average, min/max.
  always_comb begin
    sumFull     = acc + ACC_W'(conv_code_in);
    rounded     = sumFull + ROUND_TERM;
    shifted     = rounded >> LOG2_AVG;
    avgSat      = (shifted > CODE_MAX) ? '1 : shifted[DATA_W-1:0];
    firstSample = (cnt == '0);
    sampleMin   = (firstSample || (conv_code_in < blkMin)) ? conv_code_in : blkMin;
    sampleMax   = (firstSample || (conv_code_in > blkMax)) ? conv_code_in : blkMax;
    sampleEn    = (state == ACCUM) && avg_en_in && conv_done_in;
    blockEnd    = (cnt == LAST_CNT);
    // A finished block reaching a full FIFO with no pop is lost.
    fifoDrop    = pushValid & fifoFull & ~(~fifoEmpty & avg_ready_in);
  end

  // Next-state and accumulator control.
  always_comb begin
    stateNext     = state;
    accNext       = acc;
    cntNext       = cnt;
    blkMinNext    = blkMin;
    blkMaxNext    = blkMax;
    pushValidNext = 1'b0;
    pushDataNext  = pushData;
    overrunNext   = overrun_out;

    case (state)
      IDLE:    if (avg_en_in)  stateNext = ACCUM;
      ACCUM:   if (!avg_en_in) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    if ((state == ACCUM) && !avg_en_in) begin
      accNext    = '0;
      cntNext    = '0;
      blkMinNext = '0;
      blkMaxNext = '0;
    end else if (sampleEn) begin
      if (blockEnd) begin
        // Restart the block on the same edge so the next strobe is kept.
        pushValidNext        = 1'b1;
        pushDataNext.avg     = avgSat;
        pushDataNext.minCode = sampleMin;
        pushDataNext.maxCode = sampleMax;
        accNext              = '0;
        cntNext              = '0;
        blkMinNext           = '0;
        blkMaxNext           = '0;
      end else begin
        accNext    = sumFull;
        cntNext    = cnt + CNT_W'(1);
        blkMinNext = sampleMin;
        blkMaxNext = sampleMax;
      end
    end

    if (fifoDrop) begin
      overrunNext = 1'b1;
    end

    if (clear_in) begin
      accNext       = '0;
      cntNext       = '0;
      blkMinNext    = '0;
      blkMaxNext    = '0;
      pushValidNext = 1'b0;
      pushDataNext  = '0;
      overrunNext   = 1'b0;
    end
  end

  // State, accumulator and pending-result registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      blkMin      <= '0;
      blkMax      <= '0;
      pushValid   <= 1'b0;
      pushData    <= '0;
      overrun_out <= 1'b0;
    end else begin
      state       <= stateNext;
      acc         <= accNext;
      cnt         <= cntNext;
      blkMin      <= blkMinNext;
      blkMax      <= blkMaxNext;
      pushValid   <= pushValidNext;
      pushData    <= pushDataNext;
      overrun_out <= overrunNext;
    end
  end

  sar_result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk      (clk_in),
    .rst_n    (rst_in),
    .flush    (clear_in),
    .push     (pushValid),
    .pushData (pushData),
    .pop      (avg_ready_in),
    .popValid (avg_valid_out),
    .popData  (headData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .level    (level_out)
  );

  assign avg_data_out = headData.avg;
  assign avg_min_out  = headData.minCode;
  assign avg_max_out  = headData.maxCode;

endmodule

// File: tb/tb_sar_avg_buffer.sv
module tb_sar_avg_buffer;

  localparam int unsigned DW = 6;
  localparam int unsigned LW = 3;

  typedef struct packed {
    logic [DW-1:0] avg;
    logic [DW-1:0] mn;
    logic [DW-1:0] mx;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_in;
  logic          conv_done;
  logic [DW-1:0] conv_code;
  logic          avg_en;
  logic          clear;
  logic          avg_ready;
  logic          avg_valid;
  logic [DW-1:0] avg_data;
  logic [DW-1:0] avg_min;
  logic [DW-1:0] avg_max;
  logic          overrun;
  logic [LW-1:0] level;

  exp_t expQ[$];
  int   nCompared   = 0;
  int   nMismatched = 0;

  always #5 clk = ~clk;

  sar_avg_buffer #(
    .DATA_W     (DW),
    .LOG2_AVG   (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .conv_done_in  (conv_done),
    .conv_code_in  (conv_code),
    .avg_en_in     (avg_en),
    .clear_in      (clear),
    .avg_ready_in  (avg_ready),
    .avg_valid_out (avg_valid),
    .avg_data_out  (avg_data),
    .avg_min_out   (avg_min),
    .avg_max_out   (avg_max),
    .overrun_out   (overrun),
    .level_out     (level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output beat is compared against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_in && avg_valid && avg_ready) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("FAIL unexpected_result: got avg=%0d min=%0d max=%0d expected none",
                 avg_data, avg_min, avg_max);
      end else begin
        e = expQ.pop_front();
        check("result_avg", 32'(avg_data), 32'(e.avg));
        check("result_min", 32'(avg_min), 32'(e.mn));
        check("result_max", 32'(avg_max), 32'(e.mx));
      end
    end
  end

  task automatic pushExp(input int a, input int mn, input int mx);
    exp_t e;
    e.avg = DW'(a);
    e.mn  = DW'(mn);
    e.mx  = DW'(mx);
    expQ.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendCode(input int c);
    conv_done = 1'b1;
    conv_code = DW'(c);
    @(posedge clk);
    #1;
    conv_done = 1'b0;
  endtask

  task automatic sendBlock(input int a, input int b, input int c, input int d);
    sendCode(a);
    sendCode(b);
    sendCode(c);
    sendCode(d);
  endtask

  task automatic waitDrain(input string name);
    int cyc = 0;
    while (expQ.size() != 0 && cyc < 64) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check(name, 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_in    = 1'b0;
    conv_done = 1'b0;
    conv_code = '0;
    avg_en    = 1'b0;
    clear     = 1'b0;
    avg_ready = 1'b1;
    cycles(3);

    // Reset values
    check("rst_valid",   32'(avg_valid), 32'd0);
    check("rst_data",    32'(avg_data),  32'd0);
    check("rst_min",     32'(avg_min),   32'd0);
    check("rst_max",     32'(avg_max),   32'd0);
    check("rst_level",   32'(level),     32'd0);
    check("rst_overrun", 32'(overrun),   32'd0);

    rst_in = 1'b1;
    avg_en = 1'b1;
    cycles(2);

    // Basic block and one-cycle latency
    pushExp(12, 10, 13);
    sendCode(10);
    sendCode(11);
    sendCode(12);
    sendCode(13);
    check("lat_early_valid", 32'(avg_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_valid", 32'(avg_valid), 32'd1);
    check("lat_data",  32'(avg_data),  32'd12);
    waitDrain("drain_basic");

    // Rounding and no-wrap at full scale, back-to-back blocks
    pushExp(0, 0, 1);
    pushExp(2, 1, 2);
    pushExp(63, 63, 63);
    sendBlock(0, 0, 0, 1);
    sendBlock(1, 1, 2, 2);
    sendBlock(63, 63, 63, 63);
    waitDrain("drain_rounding");

    // Stalled reader: five blocks into a four-entry FIFO
    avg_ready = 1'b0;
    pushExp(3, 1, 4);
    pushExp(5, 5, 5);
    pushExp(10, 8, 11);
    pushExp(23, 20, 26);
    sendBlock(1, 2, 3, 4);
    sendBlock(5, 5, 5, 5);
    sendBlock(8, 9, 10, 11);
    sendBlock(20, 22, 24, 26);
    sendBlock(30, 30, 30, 30);
    cycles(2);
    check("ovf_level",   32'(level),     32'd4);
    check("ovf_overrun", 32'(overrun),   32'd1);
    check("ovf_valid",   32'(avg_valid), 32'd1);
    avg_ready = 1'b1;
    waitDrain("drain_overflow");
    cycles(1);
    check("ovf_level_drained", 32'(level),   32'd0);
    check("ovf_sticky",        32'(overrun), 32'd1);
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    check("clr_overrun", 32'(overrun), 32'd0);
    check("clr_level",   32'(level),   32'd0);

    // Clear with a queued result
    avg_ready = 1'b0;
    sendBlock(2, 2, 2, 2);
    cycles(2);
    check("clr_pre_level", 32'(level), 32'd1);
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    check("clr_q_level", 32'(level),     32'd0);
    check("clr_q_valid", 32'(avg_valid), 32'd0);
    avg_ready = 1'b1;

    // Clear wipes a partial block and ignores a coincident strobe
    pushExp(8, 8, 8);
    sendCode(5);
    sendCode(5);
    sendCode(5);
    clear = 1'b1;
    sendCode(60);
    clear = 1'b0;
    sendBlock(8, 8, 8, 8);
    waitDrain("drain_clear_partial");

    // Full FIFO with a block end coinciding with a pop
    avg_ready = 1'b0;
    pushExp(1, 1, 1);
    pushExp(2, 2, 2);
    pushExp(3, 3, 3);
    pushExp(4, 4, 4);
    sendBlock(1, 1, 1, 1);
    sendBlock(2, 2, 2, 2);
    sendBlock(3, 3, 3, 3);
    sendBlock(4, 4, 4, 4);
    cycles(2);
    check("full_level", 32'(level), 32'd4);
    pushExp(5, 5, 5);
    sendCode(5);
    sendCode(5);
    sendCode(5);
    sendCode(5);
    avg_ready = 1'b1;
    @(posedge clk);
    #1;
    avg_ready = 1'b0;
    check("pushpop_level",   32'(level),   32'd4);
    check("pushpop_overrun", 32'(overrun), 32'd0);
    avg_ready = 1'b1;
    waitDrain("drain_pushpop");

    // Enable dropped mid-block, strobes while idle, then a clean block
    sendCode(7);
    sendCode(7);
    avg_en = 1'b0;
    sendCode(7);
    sendCode(50);
    sendCode(50);
    avg_en = 1'b1;
    cycles(1);
    pushExp(20, 20, 20);
    sendBlock(20, 20, 20, 20);
    waitDrain("drain_enable");

    // Asynchronous reset mid-block with a queued result
    avg_ready = 1'b0;
    sendBlock(9, 9, 9, 9);
    sendCode(1);
    sendCode(1);
    cycles(1);
    check("prerst_valid", 32'(avg_valid), 32'd1);
    #2;
    rst_in = 1'b0;
    #1;
    check("arst_valid",   32'(avg_valid), 32'd0);
    check("arst_data",    32'(avg_data),  32'd0);
    check("arst_min",     32'(avg_min),   32'd0);
    check("arst_max",     32'(avg_max),   32'd0);
    check("arst_level",   32'(level),     32'd0);
    check("arst_overrun", 32'(overrun),   32'd0);
    expQ.delete();
    @(posedge clk);
    #1;
    rst_in    = 1'b1;
    avg_ready = 1'b1;
    cycles(2);
    pushExp(42, 40, 43);
    sendBlock(40, 41, 42, 43);
    waitDrain("drain_post_reset");

    cycles(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
